mem_copy_dma: RTL
=================

Name: mem_copy_dma

Overview:
- Bus-controller-side DMA engine: copies a block of 32-bit words from one bank/address to another.
- Acts as the initiator on the request/write/busy/ack bus that device arbiters and memory devices answer.
- Connects as one extra controller port on a device_arbiter; cart_control supplies start and configuration.
- Strictly one outstanding transaction; read and write transactions alternate.

Parameters:
- LENGTH_WIDTH, 20, width of word-count fields.
- ADDRESS_WIDTH, 26, byte-address width on the bus.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle start pulse; ignored while o_active=1
- i_abort  in  1  one-cycle abort pulse
- i_src_bank  in  4  source bank
- i_src_address  in  ADDRESS_WIDTH  source byte address; bits [1:0] ignored
- i_dst_bank  in  4  destination bank
- i_dst_address  in  ADDRESS_WIDTH  destination byte address; bits [1:0] ignored
- i_length  in  LENGTH_WIDTH  word count
- o_active  out  1  copy in progress
- o_done  out  1  one-cycle pulse when a copy ends (complete or aborted)
- o_aborted  out  1  sticky flag: last copy ended by abort; cleared on accepted start
- o_remaining  out  LENGTH_WIDTH  words not yet written
- o_request  out  1  bus request
- o_write  out  1  1=write, 0=read
- i_busy  in  1  bus not accepting
- i_ack  in  1  one-cycle completion pulse, for reads and writes
- o_bank  out  4  bus bank
- o_address  out  ADDRESS_WIDTH  bus byte address, word-aligned
- i_data  in  32  read data, valid when i_ack=1
- o_data  out  32  write data

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Bus handshake:
  - A transaction is accepted on any cycle with o_request=1 and i_busy=0.
  - o_request drops the cycle after acceptance.
  - o_write, o_bank, o_address and o_data are held stable from assertion of o_request until acceptance.
  - The controller then waits for i_ack.
- States:
  - IDLE: accepted i_start latches all config, clears o_aborted, loads o_remaining=i_length and asserts o_active.
    - If i_length=0: go to DONE.
    - Otherwise: go to RD_REQ.
  - RD_REQ: o_request=1, o_write=0, bank/address = source pointer. On acceptance go to RD_WAIT.
  - RD_WAIT: on i_ack, capture i_data into the holding register and go to WR_REQ.
  - WR_REQ: o_request=1, o_write=1, bank/address = destination pointer, o_data = holding register. On acceptance go to WR_WAIT.
  - WR_WAIT: on i_ack:
    - Source and destination pointers += 4, modulo 2^ADDRESS_WIDTH (wrap-around allowed, bank unchanged).
    - o_remaining -= 1.
    - If o_remaining was 1: go to DONE. Otherwise: go to RD_REQ.
  - DONE: o_done=1 for one cycle, o_active=0, return to IDLE.
- Latency:
  - i_start at cycle N gives o_request at cycle N+1.
  - The final write ack at cycle M gives o_done at cycle M+1.
- Abort, when i_abort=1 and o_active=1:
  - In RD_REQ/WR_REQ before acceptance: drop o_request next cycle, set o_aborted, go to DONE.
  - In RD_WAIT/WR_WAIT: keep waiting for i_ack, then set o_aborted and go to DONE. A pending ack is never orphaned.
  - A write already accepted completes and counts in o_remaining.
  - Abort in IDLE or DONE: ignored.
- Simultaneous events:
  - i_abort and i_ack in the same cycle: the ack is consumed (data captured or counter decremented), then the engine aborts.
  - i_start and i_abort together in IDLE: the start wins and the abort is ignored.
- An i_ack arriving in IDLE, RD_REQ or WR_REQ is ignored.
- Asserting i_reset_n low mid-transfer clears everything immediately. The bus sees o_request fall asynchronously, and the arbiter's reset covers any outstanding transaction.

Optional Feature:
- Macro: MEM_COPY_DMA_BYTESWAP_EN
- Defined:
  - Extra input port i_byteswap (1 bit), latched at start.
  - When the latch is 1, the written word swaps the bytes within each 16-bit half: {d[23:16], d[31:24], d[7:0], d[15:8]}. Used for V64-order images.
- Undefined: no port; data is copied verbatim.

Decomposition:
- Shared constants package (existing constants header): state encoding localparams for this module, plus the word-increment constant 4.
- Bank codes are reused from the existing bank definitions.
- No sub-module: a single FSM with a pointer pair, counter and holding register.

Test Plan:
- Basic copy: length=3, src ROM 0x0000100, dst ROM 0x0200000, responder ack 2 cycles after acceptance, memory holds 0xA0000001..3 → reads at 0x100/0x104/0x108, writes to 0x200000/0x200004/0x200008 with identical data, o_done once, o_remaining=0, o_aborted=0.
- Zero length: i_length=0 → no o_request ever, o_done one cycle after start.
- Backpressure: i_busy held high 5 cycles on the first read → o_request and o_address stable all 5 cycles, exactly one acceptance, copy completes correctly.
- Abort in WR_WAIT of word 2 of 4, with ack arriving the same cycle as abort → write 2 completes, o_remaining=2, o_aborted=1, o_done pulse, no further requests.
- Start while active, plus wrap: a second i_start mid-copy is ignored. src=0x3FFFFFC, length=2 → second read at 0x0000000.
- With MEM_COPY_DMA_BYTESWAP_EN and i_byteswap=1: read 0x11223344 → write 0x22114433.

Source files
------------

// File: rtl/mem_copy_dma_pkg.sv
// Shared constants for the memory-copy DMA engine: FSM encoding, word stride,
// bank codes and the V64 byte-order helper.
package mem_copy_dma_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam int WORD_INC = 4;

  localparam logic [3:0] BANK_SDRAM = 4'h0;
  localparam logic [3:0] BANK_ROM   = 4'h1;
  localparam logic [3:0] BANK_SRAM  = 4'h2;
  localparam logic [3:0] BANK_BRAM  = 4'h3;

  // Swap the two bytes inside each 16-bit half.
  function automatic logic [31:0] swap16_bytes(input logic [31:0] d);
    return {d[23:16], d[31:24], d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy DMA initiator: alternating single-word reads and writes, one outstanding transaction.
// Latency: start -> first request 1 cycle; final write ack -> o_done 1 cycle.
// Backpressure: request held with stable bus fields while i_busy=1; optional MEM_COPY_DMA_BYTESWAP_EN.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int LENGTH_WIDTH  = 20,
  parameter int ADDRESS_WIDTH = 26
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [3:0]               i_src_bank,
  input  logic [ADDRESS_WIDTH-1:0] i_src_address,
  input  logic [3:0]               i_dst_bank,
  input  logic [ADDRESS_WIDTH-1:0] i_dst_address,
  input  logic [LENGTH_WIDTH-1:0]  i_length,
`ifdef MEM_COPY_DMA_BYTESWAP_EN
  input  logic                     i_byteswap,
`endif
  output logic                     o_active,
  output logic                     o_done,
  output logic                     o_aborted,
  output logic [LENGTH_WIDTH-1:0]  o_remaining,
  output logic                     o_request,
  output logic                     o_write,
  input  logic                     i_busy,
  input  logic                     i_ack,
  output logic [3:0]               o_bank,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  input  logic [31:0]              i_data,
  output logic [31:0]              o_data
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP  = ADDRESS_WIDTH'(WORD_INC);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);
  localparam logic [LENGTH_WIDTH-1:0]  LEN_ONE    = LENGTH_WIDTH'(1);

  logic [2:0]               state;
  logic [3:0]               src_bank;
  logic [3:0]               dst_bank;
  logic [ADDRESS_WIDTH-1:0] src_ptr;
  logic [ADDRESS_WIDTH-1:0] dst_ptr;
  logic [LENGTH_WIDTH-1:0]  remaining;
  logic [31:0]              hold;
  logic                     aborted;
  logic                     abort_pend;
  logic                     accept;
  logic                     abort_now;
  logic [31:0]              rd_word;

  assign accept    = o_request && !i_busy;
  assign abort_now = i_abort || abort_pend;

`ifdef MEM_COPY_DMA_BYTESWAP_EN
  logic swap_en;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      swap_en <= 1'b0;
    end else if (state == ST_IDLE && i_start) begin
      swap_en <= i_byteswap;
    end
  end

  assign rd_word = swap_en ? swap16_bytes(i_data) : i_data;
`else
  assign rd_word = i_data;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      src_bank   <= 4'd0;
      dst_bank   <= 4'd0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      hold       <= 32'd0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            src_bank   <= i_src_bank;
            dst_bank   <= i_dst_bank;
            src_ptr    <= i_src_address & ALIGN_MASK;
            dst_ptr    <= i_dst_address & ALIGN_MASK;
            remaining  <= i_length;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            state      <= (i_length == '0) ? ST_DONE : ST_RD_REQ;
          end
        end
        // An abort coinciding with acceptance must still wait for that ack.
        ST_RD_REQ: begin
          if (accept) begin
            abort_pend <= i_abort;
            state      <= ST_RD_WAIT;
          end else if (i_abort) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_RD_WAIT: begin
          if (i_ack) begin
            hold <= rd_word;
            if (abort_now) begin
              aborted <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_WR_REQ;
            end
          end else if (i_abort) begin
            abort_pend <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (accept) begin
            abort_pend <= i_abort;
            state      <= ST_WR_WAIT;
          end else if (i_abort) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end
        end
        // The accepted write always counts, even when an abort is pending.
        ST_WR_WAIT: begin
          if (i_ack) begin
            src_ptr   <= src_ptr + ADDR_STEP;
            dst_ptr   <= dst_ptr + ADDR_STEP;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= ST_DONE;
            end else if (abort_now) begin
              aborted <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_RD_REQ;
            end
          end else if (i_abort) begin
            abort_pend <= 1'b1;
          end
        end
        ST_DONE: begin
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_bank    = 4'd0;
    o_address = '0;
    case (state)
      ST_RD_REQ, ST_RD_WAIT: begin
        o_bank    = src_bank;
        o_address = src_ptr;
      end
      ST_WR_REQ, ST_WR_WAIT: begin
        o_bank    = dst_bank;
        o_address = dst_ptr;
      end
      default: ;
    endcase
  end

  assign o_request   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign o_write     = (state == ST_WR_REQ);
  assign o_active    = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done      = (state == ST_DONE);
  assign o_aborted   = aborted;
  assign o_remaining = remaining;
  assign o_data      = hold;

endmodule
